sipo_word_receiver: RTL and testbench

- Serial-in, parallel-out word receiver: the receive end of the right-shift serial link.
- Transmitter emits its low bit (bit 0) first. This block reassembles n-bit words and presents them on a registered parallel output.
- Output side uses a valid/ready handshake.
- Sits between the serial pin logic and any word-wide consumer. Flags words lost because the consumer stalled.

---
 rtl/sipo_pkg.sv | 30 +++
 rtl/sipo_shift_stage.sv | 25 ++
 rtl/sipo_word_receiver.sv | 141 ++++++++++++++
 tb/tb_sipo_word_receiver.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sipo_pkg.sv
// Shared definitions for the SIPO word receiver.
// Build option: SIPO_PARITY_EN appends one even-parity bit to every frame.
package sipo_pkg;

  // Output buffer occupancy; ST_FULL doubles as the valid flag.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } buf_state_t;

  // Even parity: XOR over data bits plus parity bit must come out to this.
  localparam logic EVEN = 1'b0;

`ifdef SIPO_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

  // Counter width able to hold the value frame_len (clog2(frame_len+1)).
  function automatic int sipo_cw(input int frame_len);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < (frame_len + 1)) w = i + 1;
    end
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sipo_shift_stage.sv
// n-bit right-shift register: new bit enters the MSB, so after n shifts
// the first-received bit sits in bit 0. No counting lives here.
module sipo_shift_stage #(
  parameter int n = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         shift_en,
  input  logic         clear,
  input  logic         SI,
  output logic [n-1:0] sh
);

  // Shift on enable; synchronous clear wins over the shift.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh <= '0;
    end else if (clear) begin
      sh <= '0;
    end else if (shift_en) begin
      sh <= {SI, sh[n-1:1]};
    end
  end

endmodule

// File: rtl/sipo_word_receiver.sv
// Serial-in parallel-out word receiver with a one-word valid/ready buffer.
// Bit 0 arrives first. A word completing while the buffer is full and not
// being drained is dropped and flagged on the sticky overrun output.
// Build option: SIPO_PARITY_EN adds a trailing even-parity bit per frame and
// the parity_err output.
module sipo_word_receiver
  import sipo_pkg::*;
#(
  parameter  int n  = 4,
  localparam int CW = sipo_cw(n + PARITY_BITS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          SI,
  input  logic          shift_en,
  input  logic          clear,
  output logic [n-1:0]  Q,
  output logic          valid,
  input  logic          ready,
  output logic          overrun,
  output logic [CW-1:0] bit_cnt
`ifdef SIPO_PARITY_EN
  ,
  output logic          parity_err
`endif
);

  // Index of the final bit in a frame (parity bit when enabled).
  localparam logic [CW-1:0] LAST = CW'(n - 1 + PARITY_BITS);

  logic [n-1:0]  sh;
  logic [n-1:0]  word_next;
  logic          stage_en;
  logic          complete;
  logic [CW-1:0] bit_cnt_reg;
  logic [n-1:0]  q_reg;
  logic          overrun_reg;
  logic          overrun_next;
  logic          load_q;
  buf_state_t    state_reg;
  buf_state_t    state_next;

  assign complete = shift_en && (bit_cnt_reg == LAST);

`ifdef SIPO_PARITY_EN
  // The parity bit is not shifted in; data already sits aligned in sh.
  logic parity_err_reg;
  logic parity_err_next;
  assign stage_en        = shift_en && (bit_cnt_reg != LAST);
  assign word_next       = sh;
  assign parity_err_next = ((^sh) ^ SI) != EVEN;
  assign parity_err      = parity_err_reg;
`else
  // The completing bit is taken straight from SI, so sh[0] is never needed.
  logic sh_lsb_unused;
  assign stage_en      = shift_en;
  assign word_next     = {SI, sh[n-1:1]};
  assign sh_lsb_unused = sh[0];
`endif

  sipo_shift_stage #(.n(n)) u_shift (
    .clk      (clk),
    .reset    (reset),
    .shift_en (stage_en),
    .clear    (clear),
    .SI       (SI),
    .sh       (sh)
  );

  // Frame position: advances per strobe, wraps on the completing bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt_reg <= '0;
    end else if (clear) begin
      bit_cnt_reg <= '0;
    end else if (shift_en) begin
      bit_cnt_reg <= complete ? '0 : bit_cnt_reg + CW'(1);
    end
  end

  // Buffer state and sticky overrun registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= ST_EMPTY;
      overrun_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      overrun_reg <= overrun_next;
    end
  end

  // Buffer next-state: load on completion unless full and stalled.
  always_comb begin
    state_next   = state_reg;
    overrun_next = overrun_reg;
    load_q       = 1'b0;
    if (clear) begin
      state_next   = ST_EMPTY;
      overrun_next = 1'b0;
    end else begin
      case (state_reg)
        ST_EMPTY: begin
          if (complete) begin
            state_next = ST_FULL;
            load_q     = 1'b1;
          end
        end
        ST_FULL: begin
          if (complete) begin
            if (ready) load_q = 1'b1;
            else       overrun_next = 1'b1;
          end else if (ready) begin
            state_next = ST_EMPTY;
          end
        end
        default: state_next = ST_EMPTY;
      endcase
    end
  end

  // Holding register; clear leaves the last word in place.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_reg <= '0;
`ifdef SIPO_PARITY_EN
      parity_err_reg <= 1'b0;
`endif
    end else if (load_q) begin
      q_reg <= word_next;
`ifdef SIPO_PARITY_EN
      parity_err_reg <= parity_err_next;
`endif
    end
  end

  assign Q       = q_reg;
  assign valid   = (state_reg == ST_FULL);
  assign overrun = overrun_reg;
  assign bit_cnt = bit_cnt_reg;

endmodule

// File: tb/tb_sipo_word_receiver.sv
// Bench for sipo_word_receiver (n=4): a vector table of words plus
// hand-written sequences; accepted words are checked by a scoreboard queue.
module tb_sipo_word_receiver;

  localparam int N = 4;
`ifdef SIPO_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int CW = $clog2(N + PB + 1);

  logic          clk;
  logic          reset;
  logic          SI;
  logic          shift_en;
  logic          clear;
  logic          ready;
  logic [N-1:0]  Q;
  logic          valid;
  logic          overrun;
  logic [CW-1:0] bit_cnt;
`ifdef SIPO_PARITY_EN
  logic          parity_err;
`endif

  int checks = 0;
  int errors = 0;
  logic [N-1:0] exp_q[$];
  logic [N-1:0] mon_exp;

  typedef struct {
    logic [0:N-1] seq;   // bits in send order, leftmost first
    int           gap;   // idle cycles between bits
    logic [N-1:0] exp;   // word expected on Q
  } vec_t;
  vec_t vecs[6];

  sipo_word_receiver #(.n(N)) dut (
    .clk      (clk),
    .reset    (reset),
    .SI       (SI),
    .shift_en (shift_en),
    .clear    (clear),
    .Q        (Q),
    .valid    (valid),
    .ready    (ready),
    .overrun  (overrun),
    .bit_cnt  (bit_cnt)
`ifdef SIPO_PARITY_EN
    ,
    .parity_err (parity_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends one frame; ready takes rdy_last just before the final bit.
  // shift_en is left high so a following frame can run back-to-back.
  task automatic send_word(input logic [0:N-1] seq, input int gap,
                           input logic flip, input logic rdy_last);
    int total;
    total = N + PB;
    for (int i = 0; i < total; i++) begin
      logic b;
      b = (i < N) ? seq[i] : ((^seq) ^ flip);
      if (i == total - 1) ready = rdy_last;
      SI       = b;
      shift_en = 1'b1;
      tick();
      if (gap > 0 && i < total - 1) begin
        shift_en = 1'b0;
        repeat (gap) tick();
      end
    end
  endtask

  // Scoreboard consumer: every handshake must match the oldest expected word.
  always @(posedge clk) begin
    if (reset || clear) begin
      exp_q.delete();
    end else if (valid && ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL accept_unexpected: got %0h, expected no word", Q);
      end else begin
        mon_exp = exp_q.pop_front();
        check("accept_q", {28'd0, Q}, {28'd0, mon_exp});
      end
    end
  end

  initial begin
    vecs[0] = '{4'b1011, 0, 4'hD};
    vecs[1] = '{4'b0110, 2, 4'h6};
    vecs[2] = '{4'b0001, 1, 4'h8};
    vecs[3] = '{4'b1111, 0, 4'hF};
    vecs[4] = '{4'b0000, 3, 4'h0};
    vecs[5] = '{4'b0101, 1, 4'hA};

    reset = 1'b1; SI = 1'b0; shift_en = 1'b0; clear = 1'b0; ready = 1'b0;
    repeat (2) tick();
    check("rst_q", Q, 0);
    check("rst_valid", valid, 0);
    check("rst_overrun", overrun, 0);
    check("rst_bit_cnt", bit_cnt, 0);
    reset = 1'b0;
    tick();

    // Reset mid-frame discards the partial word.
    ready = 1'b1;
    SI = 1'b1; shift_en = 1'b1;
    tick(); tick();
    shift_en = 1'b0;
    check("mid_bit_cnt", bit_cnt, 2);
    #2 reset = 1'b1;
    #1 check("async_rst_bit_cnt", bit_cnt, 0);
    tick();
    reset = 1'b0;
    tick();
    exp_q.push_back(4'h6);
    send_word(4'b0110, 0, 1'b0, 1'b1);
    check("post_rst_q", Q, 4'h6);
    check("post_rst_valid", valid, 1);
    shift_en = 1'b0;
    tick();
    check("post_rst_drained", valid, 0);

    // Table of words, consumer always ready.
    for (int k = 0; k < 6; k++) begin
      ready = 1'b1;
      exp_q.push_back(vecs[k].exp);
      send_word(vecs[k].seq, vecs[k].gap, 1'b0, 1'b1);
      check($sformatf("vec%0d_valid", k), valid, 1);
      check($sformatf("vec%0d_q", k), Q, vecs[k].exp);
      check($sformatf("vec%0d_bit_cnt", k), bit_cnt, 0);
      check($sformatf("vec%0d_overrun", k), overrun, 0);
`ifdef SIPO_PARITY_EN
      check($sformatf("vec%0d_parity_err", k), parity_err, 0);
`endif
      shift_en = 1'b0;
      tick();
      check($sformatf("vec%0d_drained", k), valid, 0);
    end

    // Gapped strobes with a stalled consumer: Q must hold.
    ready = 1'b0;
    exp_q.push_back(4'h8);
    send_word(4'b0001, 2, 1'b0, 1'b0);
    shift_en = 1'b0;
    for (int s = 0; s < 3; s++) begin
      check($sformatf("stall%0d_valid", s), valid, 1);
      check($sformatf("stall%0d_q", s), Q, 4'h8);
      tick();
    end
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check("stall_drained", valid, 0);

    // Back-to-back words, accept coincides with the second completion.
    exp_q.push_back(4'hA);
    exp_q.push_back(4'h5);
    send_word(4'b0101, 0, 1'b0, 1'b0);
    check("b2b_first_q", Q, 4'hA);
    send_word(4'b1010, 0, 1'b0, 1'b1);
    check("b2b_second_q", Q, 4'h5);
    check("b2b_valid", valid, 1);
    check("b2b_overrun", overrun, 0);
    shift_en = 1'b0;
    tick();
    ready = 1'b0;
    check("b2b_drained", valid, 0);

    // Overrun: second word dropped while first is unread, then clear.
    exp_q.push_back(4'h3);
    send_word(4'b1100, 0, 1'b0, 1'b0);
    send_word(4'b0011, 1, 1'b0, 1'b0);
    shift_en = 1'b0;
    check("ovr_q", Q, 4'h3);
    check("ovr_valid", valid, 1);
    check("ovr_flag", overrun, 1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_valid", valid, 0);
    check("clr_overrun", overrun, 0);
    check("clr_bit_cnt", bit_cnt, 0);
    check("clr_q_kept", Q, 4'h3);

    // clear beats a simultaneous strobe; following frame starts clean.
    ready = 1'b1;
    SI = 1'b1; shift_en = 1'b1;
    tick(); tick();
    check("pre_clr_bit_cnt", bit_cnt, 2);
    clear = 1'b1;
    tick();
    clear = 1'b0; shift_en = 1'b0;
    check("clr_vs_shift_bit_cnt", bit_cnt, 0);
    exp_q.push_back(4'h9);
    send_word(4'b1001, 0, 1'b0, 1'b1);
    check("after_clr_q", Q, 4'h9);
    shift_en = 1'b0;
    tick();
    check("after_clr_drained", valid, 0);

`ifdef SIPO_PARITY_EN
    // Good parity then bad parity on the same data.
    exp_q.push_back(4'h3);
    send_word(4'b1100, 0, 1'b0, 1'b0);
    check("par_good_q", Q, 4'h3);
    check("par_good_err", parity_err, 0);
    shift_en = 1'b0; ready = 1'b1;
    tick();
    ready = 1'b0;
    exp_q.push_back(4'h3);
    send_word(4'b1100, 0, 1'b1, 1'b0);
    check("par_bad_err", parity_err, 1);
    check("par_bad_valid", valid, 1);
    shift_en = 1'b0; ready = 1'b1;
    tick();
    ready = 1'b0;
`endif

    tick();
    check("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
